// File: rtl/cpu_mem_port.sv
// rtl/cpu_mem_port.sv - wait-stated word RAM port for the CPU core; MEM_ACCESS_CNT_EN adds an access counter
module cpu_mem_port #(
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 write,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 ready,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          access_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [WORD_SIZE-1:0] mem [0:DEPTH-1];

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 write_q, write_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 in_range;
    logic                 mem_we;
    logic [IDX_W-1:0]     idx;

    // Out-of-range addresses are errors, never aliased onto the array.
    assign in_range = {{(32-ADDR_W){1'b0}}, addr_q} < 32'(DEPTH);
    assign idx      = addr_q[IDX_W-1:0];
    assign mem_we   = (state_q == S_ACCESS) && write_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (req) begin
                addr_d  = addr;
                write_d = write;
                wdata_d = wdata;
                cnt_d   = WAIT_LOAD;
                state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                if (!write_q) rdata_d = in_range ? mem[idx] : '0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_q == S_ACCESS);
        err_d   = (state_q == S_ACCESS) && !in_range;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wdata_q;
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] acc_cnt_q, acc_cnt_d;

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (state_q == S_DONE && acc_cnt_q != 16'hFFFF) acc_cnt_d = acc_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt_q <= 16'h0000;
        else        acc_cnt_q <= acc_cnt_d;
    end

    assign access_cnt = acc_cnt_q;
`else
    assign access_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_cpu_mem_port.sv
// tb/tb_cpu_mem_port.sv - table-driven bench for cpu_mem_port (main, DEPTH=16 and WAIT_CYCLES=0 instances)
module tb_cpu_mem_port;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   [3];
    logic        write [3];
    logic [7:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        busy  [3];
    logic        err   [3];
    logic [15:0] access_cnt [3];

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cpu_mem_port #(.WORD_SIZE(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) u_main (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .write(write[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .err(err[0]), .access_cnt(access_cnt[0]));

    cpu_mem_port #(.WORD_SIZE(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(2)) u_small (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .write(write[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .err(err[1]), .access_cnt(access_cnt[1]));

    cpu_mem_port #(.WORD_SIZE(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .write(write[2]), .addr(addr[2]), .wdata(wdata[2]),
        .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]), .err(err[2]), .access_cnt(access_cnt[2]));

    typedef struct {
        int          d;
        logic        w;
        logic [7:0]  a;
        logic [31:0] wd;
        logic        mut;
        logic [31:0] er;
        logic        ee;
        int          el;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm);
`ifdef MEM_ACCESS_CNT_EN
        chk(nm, {16'h0, access_cnt[0]}, exp_cnt);
`else
        chk(nm, {16'h0, access_cnt[0]}, 32'h0);
`endif
    endtask

    // Issue one access from IDLE; lat counts the cycle after acceptance as 1.
    task automatic run(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd,
                       input logic mut, output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        req[d] = 1'b1; write[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        @(negedge clk);
        req[d] = 1'b0;
        if (mut) begin
            addr[d] = 8'h06; wdata[d] = 32'h1; write[d] = 1'b1;
        end
        lat = 1;
        chk("busy_after_accept", {31'h0, busy[d]}, 32'h1);
        while (!ready[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata[d];
        e  = err[d];
        if (d == 0) exp_cnt++;
        @(negedge clk);
        chk("ready_one_cycle", {31'h0, ready[d]}, 32'h0);
        chk("err_one_cycle", {31'h0, err[d]}, 32'h0);
        chk("busy_back_idle", {31'h0, busy[d]}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          n, first, second;
        bit          seen;

        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; write[i] = 1'b0; addr[i] = 8'h0; wdata[i] = 32'h0;
        end

        tbl[0]  = '{0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 4};
        tbl[1]  = '{0, 1'b0, 8'h05, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 4};
        tbl[2]  = '{0, 1'b1, 8'h06, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF, 1'b0, 4};
        tbl[3]  = '{0, 1'b0, 8'h06, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 4};
        tbl[4]  = '{0, 1'b1, 8'h07, 32'hA5A5A5A5, 1'b1, 32'hCAFEF00D, 1'b0, 4};
        tbl[5]  = '{0, 1'b0, 8'h07, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b0, 4};
        tbl[6]  = '{0, 1'b0, 8'h06, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 4};
        tbl[7]  = '{0, 1'b1, 8'hFF, 32'h0BADF00D, 1'b0, 32'hCAFEF00D, 1'b0, 4};
        tbl[8]  = '{0, 1'b0, 8'hFF, 32'h0,        1'b0, 32'h0BADF00D, 1'b0, 4};
        tbl[9]  = '{1, 1'b1, 8'h00, 32'h11112222, 1'b0, 32'h00000000, 1'b0, 4};
        tbl[10] = '{1, 1'b0, 8'h00, 32'h0,        1'b0, 32'h11112222, 1'b0, 4};
        tbl[11] = '{1, 1'b1, 8'h20, 32'hFFFFFFFF, 1'b0, 32'h11112222, 1'b1, 4};
        tbl[12] = '{1, 1'b0, 8'h20, 32'h0,        1'b0, 32'h00000000, 1'b1, 4};
        tbl[13] = '{1, 1'b0, 8'h00, 32'h0,        1'b0, 32'h11112222, 1'b0, 4};
        tbl[14] = '{1, 1'b1, 8'h0F, 32'h0F0F0F0F, 1'b0, 32'h11112222, 1'b0, 4};
        tbl[15] = '{1, 1'b0, 8'h0F, 32'h0,        1'b0, 32'h0F0F0F0F, 1'b0, 4};
        tbl[16] = '{1, 1'b0, 8'h10, 32'h0,        1'b0, 32'h00000000, 1'b1, 4};
        tbl[17] = '{2, 1'b1, 8'h03, 32'h00000077, 1'b0, 32'h00000000, 1'b0, 2};
        tbl[18] = '{2, 1'b0, 8'h03, 32'h0,        1'b0, 32'h00000077, 1'b0, 2};

        repeat (2) @(negedge clk);
        chk("reset_rdata", rdata[0], 32'h0);
        chk("reset_ready", {31'h0, ready[0]}, 32'h0);
        chk("reset_busy", {31'h0, busy[0]}, 32'h0);
        chk("reset_err", {31'h0, err[0]}, 32'h0);
        chk_cnt("reset_access_cnt");
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].mut, rd, e, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].er);
            chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, tbl[i].ee});
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].el);
        end

        // req held high through DONE: next acceptance in the following IDLE cycle
        @(negedge clk);
        req[0] = 1'b1; write[0] = 1'b0; addr[0] = 8'h05;
        n = 0; first = -1; second = -1;
        while (second < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (ready[0]) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        req[0] = 1'b0;
        exp_cnt += 2;
        chk("held_req_rdata", rdata[0], 32'hDEADBEEF);
        chk("held_req_period", second - first, 5);
        repeat (3) @(negedge clk);

        run(0, 1'b1, 8'h09, 32'h00000099, 1'b0, rd, e, lat);
        chk_cnt("access_cnt_before_reset");

        // reset during WAIT aborts the store
        @(negedge clk);
        req[0] = 1'b1; write[0] = 1'b1; addr[0] = 8'h09; wdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        chk("abort_busy", {31'h0, busy[0]}, 32'h0);
        chk("abort_rdata", rdata[0], 32'h0);
        chk_cnt("abort_access_cnt");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ready[0]) seen = 1'b1;
        end
        chk("abort_no_ready", {31'h0, seen}, 32'h0);

        run(0, 1'b0, 8'h09, 32'h0, 1'b0, rd, e, lat);
        chk("abort_readback", rd, 32'h00000099);
        chk_cnt("access_cnt_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_mem_port.md
Name: cpu_mem_port

Overview:
Memory-side port that serves the multi-cycle CPU core's instruction-fetch and load/store requests.
- Holds a word-addressed RAM array.
- Inserts a programmable number of wait states per access.
- Returns read data with a one-cycle ready pulse.
- Sits directly downstream of the core: it consumes the core's address, write strobe and store data, and produces the word the core reads back.

Parameters:
WORD_SIZE, 32, data word width in bits
ADDR_W, 8, address width (word index)
DEPTH, 256, number of words implemented (1..2^ADDR_W)
WAIT_CYCLES, 2, wait states inserted before each array access (0..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
req  input  1  access request, sampled only in IDLE
write  input  1  1 = store, 0 = load; sampled with req
addr  input  ADDR_W  word address; sampled with req
wdata  input  WORD_SIZE  store data; sampled with req
rdata  output  WORD_SIZE  load data; valid when ready=1, held until next load completes
ready  output  1  one-cycle completion pulse (loads and stores)
busy  output  1  high in every non-IDLE state
err  output  1  one-cycle pulse with ready when addr >= DEPTH
access_cnt  output  16  completed-access counter (see Optional Feature)

Behaviour:
Reset (rst_n=0, async), outputs:
- state=IDLE, rdata=0, ready=0, busy=0, err=0, access_cnt=0.
- Wait counter = 0.
- RAM contents are not reset.

FSM states: IDLE, WAIT, ACCESS, DONE.

IDLE:
- If req=1, latch addr/write/wdata into internal registers.
- Go to WAIT if WAIT_CYCLES>0, else go to ACCESS. Load the wait counter with WAIT_CYCLES-1.
- If req=0, stay in IDLE.

WAIT:
- Counter decrements each cycle.
- At 0, go to ACCESS.
- Total cycles spent in WAIT = WAIT_CYCLES.

ACCESS:
- In-range store: mem[addr_q] <= wdata_q.
- In-range load: rdata <= mem[addr_q].
- Out of range (addr_q >= DEPTH): store dropped, load returns 0, err_q set.
- Go to DONE.

DONE:
- ready=1 for exactly this cycle; err=err_q.
- Go to IDLE unconditionally.

Latency:
- req accepted at edge N gives ready high in cycle N+WAIT_CYCLES+2.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.

Handshake and boundary rules:
- req, addr, write and wdata are ignored while busy=1; there is no queueing. Upstream must hold req or re-issue it after ready.
- req held high through DONE is accepted in the following IDLE cycle.
- Changes to addr or wdata after acceptance have no effect on the access in flight.
- rdata is unchanged by stores and by out-of-range stores.
- Reset asserted in WAIT aborts the access: no array write occurs, and no ready is produced.
- Reset asserted in ACCESS: whether the array write lands is undefined; the bench must not check it.
- Address arithmetic is purely the index. There is no wrap: addresses >= DEPTH are errors, not aliased.

Optional Feature:
Macro MEM_ACCESS_CNT_EN.
- Defined: access_cnt increments on every DONE cycle, including err accesses. It saturates at 16'hFFFF and resets to 0.
- Undefined: no counter register is built and access_cnt is tied to 16'h0000.

Test Plan:
All scenarios use WAIT_CYCLES=2 and DEPTH=256 unless noted.
- Reset, then req=1, write=1, addr=8'h05, wdata=32'hDEADBEEF at edge 0 -> busy=1 from cycle 1; ready pulse in cycle 4; err=0.
- Then load from addr=8'h05 -> ready in cycle 4 after acceptance with rdata=32'hDEADBEEF. rdata is held after a following store to 8'h06 completes.
- Change addr to 8'h06 and wdata to 32'h1 one cycle after acceptance of a store to 8'h07 = 32'hA5A5A5A5 -> readback of 8'h07 is 32'hA5A5A5A5; 8'h06 is unchanged.
- DEPTH=16, load from addr=8'h20 -> rdata=0 and err=1 together with ready. A store to 8'h20 also gives err=1, and readback of addr 8'h00 is unaffected.
- Assert rst_n=0 during the WAIT of a store of 32'h12345678 to 8'h09 -> no ready pulse; busy=0 immediately; a later load of 8'h09 returns the previous contents.
- MEM_ACCESS_CNT_EN defined, 5 accesses -> access_cnt=5; undefined -> access_cnt stays 0. WAIT_CYCLES=0 -> ready 2 cycles after acceptance.
